// File: rtl/calc_frame_seq_if.sv
// calc_frame_seq_if: byte stream in, calc operand/result link, and result stream out for the frame sequencer.
interface calc_frame_seq_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] calc_a;
    logic [WIDTH-1:0] calc_b;
    logic [WIDTH-1:0] calc_c;
    logic [1:0]       calc_op;
    logic [WIDTH-1:0] calc_r;
    logic             calc_cout;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_valid;
    logic             out_ready;
    logic             err;
    logic             busy;
    modport master (
        input  in_data, in_valid, calc_r, calc_cout, out_ready,
        output in_ready, calc_a, calc_b, calc_c, calc_op, out_data, out_carry, out_valid, err, busy
    );
    modport slave (
        output in_data, in_valid, calc_r, calc_cout, out_ready,
        input  in_ready, calc_a, calc_b, calc_c, calc_op, out_data, out_carry, out_valid, err, busy
    );
endinterface

// File: rtl/calc_frame_seq.sv
// calc_frame_seq: collects CMD,A,B,C frames, drives the calc operands and offers the captured result downstream.
module calc_frame_seq #(
    parameter int       WIDTH   = 8,
    parameter int       TIMEOUT = 255,
    parameter logic [3:0] CMD_TAG = 4'hA
) (
    input logic clk,
    input logic rst_n,
    calc_frame_seq_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, GET_A, GET_B, GET_C, EXEC, HOLD} state_t;
    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          up, hs, tag_ok, collecting, expired, err_nx;
    // up keeps in_ready low until the first edge after reset release
    assign bus.in_ready = up && (state inside {IDLE, GET_A, GET_B, GET_C});
    assign bus.busy     = state != IDLE;
    assign hs           = bus.in_valid && bus.in_ready;
    assign tag_ok       = bus.in_data[7:4] == CMD_TAG;
    assign collecting   = state inside {GET_A, GET_B, GET_C};
    assign expired      = collecting && !hs && cnt == CW'(TIMEOUT);
    assign err_nx       = (state == IDLE && hs && !tag_ok) || expired;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (hs && tag_ok) ? GET_A : IDLE;
            GET_A:   state_nx = hs ? GET_B : expired ? IDLE : GET_A;
            GET_B:   state_nx = hs ? GET_C : expired ? IDLE : GET_B;
            GET_C:   state_nx = hs ? EXEC : expired ? IDLE : GET_C;
            EXEC:    state_nx = HOLD;
            HOLD:    state_nx = bus.out_ready ? IDLE : HOLD;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            up            <= 1'b0;
            bus.err       <= 1'b0;
            bus.calc_op   <= '0;
            bus.calc_a    <= '0;
            bus.calc_b    <= '0;
            bus.calc_c    <= '0;
            bus.out_data  <= '0;
            bus.out_carry <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            state   <= state_nx;
            up      <= 1'b1;
            bus.err <= err_nx;
            // cleared on handshake, on every state change and outside collection
            cnt     <= (collecting && !hs && state_nx == state) ? cnt + CW'(1) : '0;
            if (state == IDLE && hs && tag_ok) bus.calc_op <= bus.in_data[1:0];
            if (state == GET_A && hs) bus.calc_a <= bus.in_data;
            if (state == GET_B && hs) bus.calc_b <= bus.in_data;
            if (state == GET_C && hs) bus.calc_c <= bus.in_data;
            if (state == EXEC) begin
                bus.out_data  <= bus.calc_r[WIDTH-1:0];
                bus.out_carry <= bus.calc_cout;
                bus.out_valid <= 1'b1;
            end else if (state == HOLD && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_calc_frame_seq.sv
// tb_calc_frame_seq: directed frames against calc_frame_seq with calc modelled as r=a+b+c, cout=0.
module tb_calc_frame_seq;
    localparam int TO = 6;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   err_seen = 0;
    int   e0;
    calc_frame_seq_if #(.WIDTH(8)) bus();
    assign bus.calc_r    = bus.calc_a + bus.calc_b + bus.calc_c;
    assign bus.calc_cout = 1'b0;
    calc_frame_seq #(.WIDTH(8), .TIMEOUT(TO), .CMD_TAG(4'hA)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (bus.err) err_seen++;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [7:0] b);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        tick(1);
        bus.in_valid = 1'b0;
    endtask
    task automatic frame(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send(cmd);
        send(a);
        send(b);
        send(c);
    endtask
    initial begin
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick(2);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err, 0);
        check("rst_calc_a", bus.calc_a, 0);
        @(negedge clk) rst_n = 1'b1;
        tick(1);
        check("post_rst_in_ready", bus.in_ready, 1);
        // 1: basic frame and latency
        frame(8'hA3, 8'h05, 8'h0A, 8'h14);
        check("t1_exec_valid", bus.out_valid, 0);
        check("t1_exec_in_ready", bus.in_ready, 0);
        check("t1_op", bus.calc_op, 3);
        tick(1);
        check("t1_valid", bus.out_valid, 1);
        check("t1_data", bus.out_data, 8'h23);
        check("t1_carry", bus.out_carry, 0);
        tick(1);
        check("t1_done_valid", bus.out_valid, 0);
        check("t1_done_busy", bus.busy, 0);
        check("t1_no_err", err_seen, 0);
        // 2: bad tag then a good frame
        send(8'h53);
        check("t2_err", bus.err, 1);
        check("t2_idle", bus.busy, 0);
        tick(1);
        check("t2_err_pulse", bus.err, 0);
        check("t2_err_cnt", err_seen, 1);
        frame(8'hA0, 8'hFF, 8'h01, 8'h01);
        tick(1);
        check("t2_data", bus.out_data, 8'h01);
        check("t2_op", bus.calc_op, 0);
        tick(1);
        // 3: downstream stall in HOLD
        bus.out_ready = 1'b0;
        frame(8'hA1, 8'h10, 8'h20, 8'h30);
        tick(1);
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_valid", bus.out_valid, 1);
            check("t3_hold_in_ready", bus.in_ready, 0);
            check("t3_hold_data", bus.out_data, 8'h60);
            tick(1);
        end
        bus.out_ready = 1'b1;
        tick(1);
        check("t3_rel_valid", bus.out_valid, 0);
        check("t3_rel_busy", bus.busy, 0);
        check("t3_rel_in_ready", bus.in_ready, 1);
        // 4: inter-byte timeout aborts the frame
        e0 = err_seen;
        send(8'hA1);
        send(8'h10);
        tick(TO);
        check("t4_pre_busy", bus.busy, 1);
        check("t4_pre_err", bus.err, 0);
        tick(1);
        check("t4_abort_busy", bus.busy, 0);
        check("t4_abort_err", bus.err, 1);
        check("t4_abort_valid", bus.out_valid, 0);
        tick(1);
        check("t4_err_cnt", err_seen - e0, 1);
        frame(8'hA2, 8'h07, 8'h08, 8'h09);
        tick(1);
        check("t4_data", bus.out_data, 8'h18);
        check("t4_op", bus.calc_op, 2);
        tick(1);
        // 5: byte exactly at the timeout count is accepted
        e0 = err_seen;
        send(8'hA1);
        send(8'h01);
        tick(TO);
        send(8'h02);
        check("t5_busy", bus.busy, 1);
        check("t5_b", bus.calc_b, 8'h02);
        send(8'h04);
        tick(1);
        check("t5_data", bus.out_data, 8'h07);
        tick(1);
        check("t5_no_err", err_seen - e0, 0);
        // 6: reset in HOLD and mid-frame
        bus.out_ready = 1'b0;
        frame(8'hA1, 8'h01, 8'h01, 8'h01);
        tick(1);
        check("t6_hold_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", bus.out_valid, 0);
        @(negedge clk) rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick(1);
        send(8'hA2);
        send(8'h55);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_a", bus.calc_a, 0);
        check("t6_rst_in_ready", bus.in_ready, 0);
        @(negedge clk) rst_n = 1'b1;
        tick(1);
        frame(8'hA2, 8'h01, 8'h02, 8'h03);
        tick(1);
        check("t6_data", bus.out_data, 8'h06);
        check("t6_a", bus.calc_a, 8'h01);
        check("t6_op", bus.calc_op, 2);
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
